// File: rtl/ram_2r1w_arbiter.sv
// ram_2r1w_arbiter: round-robin front end packing up to two reads and one
// write per cycle onto a 2-read/1-write RAM, with optional zero-fill.
// Ports: clk/rst; req_valid/req_we/req_addr/req_wdata -> req_ready grants;
// rsp_valid/rsp_rdata one-cycle read returns; init_done once accepting;
// ram_we/ram_addrw/ram_dinw write port, ram_addr1/2 -> ram_dout1/2 reads.
module ram_2r1w_arbiter #(
    parameter int NREQ           = 4,
    parameter int AW             = 11,
    parameter int DW             = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [NREQ*DW-1:0]   rsp_rdata,
    output logic                 init_done,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addrw,
    output logic [DW-1:0]        ram_dinw,
    output logic [AW-1:0]        ram_addr1,
    output logic [AW-1:0]        ram_addr2,
    input  logic [DW-1:0]        ram_dout1,
    input  logic [DW-1:0]        ram_dout2
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // Response tags, one per RAM read port
    logic          t1_v_q, t2_v_q;
    logic          t1_byp_q, t2_byp_q;
    logic [PW-1:0] t1_id_q, t2_id_q;
    logic [DW-1:0] t1_bd_q, t2_bd_q;

    logic [AW-1:0] addr_a  [NREQ];
    logic [DW-1:0] wdata_a [NREQ];
    logic [DW-1:0] rdata_a [NREQ];

    logic          run;
    logic          wr_hit, rd1_hit, rd2_hit;
    logic [PW-1:0] wr_idx, rd1_idx, rd2_idx, idx;
    logic          byp1, byp2;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] x);
        return (x == PW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i]  = req_addr[i*AW +: AW];
            wdata_a[i] = req_wdata[i*DW +: DW];
        end
    end

    assign run       = (state_q == RUN) && !rst;
    assign init_done = run;

    // Rotating priority search, starting at each pointer
    always_comb begin
        wr_hit  = 1'b0;
        rd1_hit = 1'b0;
        rd2_hit = 1'b0;
        wr_idx  = '0;
        rd1_idx = '0;
        rd2_idx = '0;
        idx     = '0;
        if (run) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = PW'((int'(wr_ptr_q) + k) % NREQ);
                if (!wr_hit && req_valid[idx] && req_we[idx]) begin
                    wr_hit = 1'b1;
                    wr_idx = idx;
                end
            end
            for (int k = 0; k < NREQ; k++) begin
                idx = PW'((int'(rd_ptr_q) + k) % NREQ);
                if (req_valid[idx] && !req_we[idx]) begin
                    if (!rd1_hit) begin
                        rd1_hit = 1'b1;
                        rd1_idx = idx;
                    end else if (!rd2_hit) begin
                        rd2_hit = 1'b1;
                        rd2_idx = idx;
                    end
                end
            end
        end
    end

    // Same-cycle read/write to one address returns the new data
    assign byp1 = wr_hit && rd1_hit && (addr_a[wr_idx] == addr_a[rd1_idx]);
    assign byp2 = wr_hit && rd2_hit && (addr_a[wr_idx] == addr_a[rd2_idx]);

    assign wr_ptr_d = wr_hit  ? nxt(wr_idx)  : wr_ptr_q;
    assign rd_ptr_d = rd2_hit ? nxt(rd2_idx) :
                      rd1_hit ? nxt(rd1_idx) : rd_ptr_q;

    always_comb begin
        req_ready = '0;
        ram_we    = 1'b0;
        ram_addrw = '0;
        ram_dinw  = '0;
        ram_addr1 = '0;
        ram_addr2 = '0;
        if (!rst) begin
            if (state_q == INIT) begin
                ram_we    = 1'b1;
                ram_addrw = cnt_q;
            end else begin
                if (wr_hit) begin
                    req_ready[wr_idx] = 1'b1;
                    ram_we            = 1'b1;
                    ram_addrw         = addr_a[wr_idx];
                    ram_dinw          = wdata_a[wr_idx];
                end
                if (rd1_hit) begin
                    req_ready[rd1_idx] = 1'b1;
                    ram_addr1          = addr_a[rd1_idx];
                end
                if (rd2_hit) begin
                    req_ready[rd2_idx] = 1'b1;
                    ram_addr2          = addr_a[rd2_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR_ON_RESET ? INIT : RUN;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            t1_v_q   <= 1'b0;
            t2_v_q   <= 1'b0;
            t1_byp_q <= 1'b0;
            t2_byp_q <= 1'b0;
            t1_id_q  <= '0;
            t2_id_q  <= '0;
            t1_bd_q  <= '0;
            t2_bd_q  <= '0;
        end else begin
            if (state_q == INIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (&cnt_q) state_q <= RUN;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            t1_v_q   <= rd1_hit;
            t2_v_q   <= rd2_hit;
            t1_byp_q <= byp1;
            t2_byp_q <= byp2;
            t1_id_q  <= rd1_idx;
            t2_id_q  <= rd2_idx;
            t1_bd_q  <= ram_dinw;
            t2_bd_q  <= ram_dinw;
        end
    end

    // Tags never share an id: a requester gets at most one grant
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int i = 0; i < NREQ; i++) rdata_a[i] = '0;
        if (!rst) begin
            if (t1_v_q) begin
                rsp_valid[t1_id_q] = 1'b1;
                rdata_a[t1_id_q]   = t1_byp_q ? t1_bd_q : ram_dout1;
            end
            if (t2_v_q) begin
                rsp_valid[t2_id_q] = 1'b1;
                rdata_a[t2_id_q]   = t2_byp_q ? t2_bd_q : ram_dout2;
            end
        end
        for (int i = 0; i < NREQ; i++) rsp_rdata[i*DW +: DW] = rdata_a[i];
    end

endmodule

// File: tb/tb_ram_2r1w_arbiter.sv
// tb_ram_2r1w_arbiter: table vectors, hand sequences and random load
// against a distance-based arbitration and memory model.
module tb_ram_2r1w_arbiter;
    localparam int NREQ  = 4;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_we = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ*DW-1:0]   rsp_rdata;
    logic                 init_done;
    logic                 ram_we;
    logic [AW-1:0]        ram_addrw, ram_addr1, ram_addr2;
    logic [DW-1:0]        ram_dinw, ram_dout1, ram_dout2;

    always #5 clk = ~clk;

    ram_2r1w_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .ram_we(ram_we), .ram_addrw(ram_addrw), .ram_dinw(ram_dinw),
        .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
        .ram_dout1(ram_dout1), .ram_dout2(ram_dout2)
    );

    // RAM: never-written words read as nonzero garbage
    logic [DW-1:0] ram  [DEPTH];
    bit            seen [DEPTH];

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        return seen[a] ? ram[a] : ({21'h0, a} ^ 32'hC0FF_EE00);
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addrw]  <= ram_dinw;
            seen[ram_addrw] <= 1'b1;
        end
        ram_dout1 <= ram_rd(ram_addr1);
        ram_dout2 <= ram_rd(ram_addr2);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0]      mm [DEPTH];
    int                 rptr, wptr;
    logic [NREQ-1:0]    ev;
    logic [NREQ*DW-1:0] ed;
    logic [AW-1:0]      a_in [NREQ];
    logic [DW-1:0]      d_in [NREQ];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        rptr = 0;
        wptr = 0;
        ev   = '0;
        ed   = '0;
    endtask

    // One RUN cycle: grants go to the nearest candidates ahead of the pointers
    task automatic run_cycle(input logic [NREQ-1:0] v,
                             input logic [NREQ-1:0] we);
        int ws, r1, r2, dw, d1, d2, d, last;
        logic [NREQ-1:0]    er, nev;
        logic [AW-1:0]      ea1, ea2;
        logic [NREQ*DW-1:0] ned;
        ws = -1; r1 = -1; r2 = -1;
        dw = NREQ; d1 = NREQ; d2 = NREQ;
        @(posedge clk);
        #1;
        req_valid = v;
        req_we    = we;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = a_in[i];
            req_wdata[i*DW +: DW] = d_in[i];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                d = (i - (we[i] ? wptr : rptr) + NREQ) % NREQ;
                if (we[i]) begin
                    if (d < dw) begin dw = d; ws = i; end
                end else if (d < d1) begin
                    r2 = r1; d2 = d1; r1 = i; d1 = d;
                end else if (d < d2) begin
                    r2 = i; d2 = d;
                end
            end
        end
        er = '0; ea1 = '0; ea2 = '0;
        if (ws >= 0) er[ws] = 1'b1;
        if (r1 >= 0) begin er[r1] = 1'b1; ea1 = a_in[r1]; end
        if (r2 >= 0) begin er[r2] = 1'b1; ea2 = a_in[r2]; end
        @(negedge clk);
        chk("ready", req_ready, er);
        chk("ram_we", ram_we, ws >= 0);
        if (ws >= 0) chk("ram_wport", {ram_addrw, ram_dinw}, {a_in[ws], d_in[ws]});
        chk("ram_raddr", {ram_addr1, ram_addr2}, {ea1, ea2});
        chk("init_done", init_done, 1'b1);
        chk("rsp_valid", rsp_valid, ev);
        chk("rsp_rdata", rsp_rdata, ed);
        nev = '0;
        ned = '0;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? r1 : r2;
            if (d >= 0) begin
                nev[d] = 1'b1;
                if (ws >= 0 && a_in[ws] == a_in[d])
                    ned[d*DW +: DW] = d_in[ws];
                else
                    ned[d*DW +: DW] = mm[a_in[d]];
            end
        end
        if (ws >= 0) begin
            mm[a_in[ws]] = d_in[ws];
            wptr = (ws + 1) % NREQ;
        end
        last = (r2 >= 0) ? r2 : r1;
        if (last >= 0) rptr = (last + 1) % NREQ;
        ev = nev;
        ed = ned;
    endtask

    task automatic reset_for(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(negedge clk);
            chk("rst_outs", {req_ready, rsp_valid, init_done, ram_we,
                ram_addrw, ram_addr1, ram_addr2, ram_dinw}, '0);
            chk("rst_rdata", rsp_rdata, '0);
        end
    endtask

    task automatic init_phase();
        logic [127:0] exp;
        for (int c = 0; c < DEPTH; c++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            exp = {1'b1, AW'(c), 32'h0, 4'h0, 1'b0, 4'h0};
            chk("init", {ram_we, ram_addrw, ram_dinw, req_ready,
                init_done, rsp_valid}, exp);
        end
    endtask

    typedef struct {
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] we;
        logic [NREQ-1:0] rdy;
    } vec_t;

    vec_t tab [12];

    initial begin
        int w, dr;
        logic [NREQ-1:0] v;
        // preload 10..13, read rotation, then write rotation with a reader
        tab[0]  = '{4'b1111, 4'b1111, 4'b0001};
        tab[1]  = '{4'b1111, 4'b1111, 4'b0010};
        tab[2]  = '{4'b1111, 4'b1111, 4'b0100};
        tab[3]  = '{4'b1111, 4'b1111, 4'b1000};
        tab[4]  = '{4'b1111, 4'b0000, 4'b1100};
        tab[5]  = '{4'b1111, 4'b0000, 4'b0011};
        tab[6]  = '{4'b1111, 4'b0000, 4'b1100};
        tab[7]  = '{4'b1111, 4'b0000, 4'b0011};
        tab[8]  = '{4'b1011, 4'b1010, 4'b0011};
        tab[9]  = '{4'b1011, 4'b1010, 4'b1001};
        tab[10] = '{4'b1011, 4'b1010, 4'b0011};
        tab[11] = '{4'b1011, 4'b1010, 4'b1001};

        for (int i = 0; i < NREQ; i++) begin
            a_in[i] = 11'd5;
            d_in[i] = '0;
            req_addr[i*AW +: AW] = 11'd5;
        end
        req_valid = 4'b1111;

        reset_for(3);
        init_phase();
        model_reset();
        run_cycle(4'b1111, 4'b0000);
        chk("first_grant", req_ready, 4'b0011);
        run_cycle(4'b0000, 4'b0000);
        chk("clear_rd5_v", rsp_valid, 4'b0011);
        chk("clear_rd5_d", rsp_rdata, '0);

        for (int i = 0; i < NREQ; i++) begin
            a_in[i] = AW'(10 + i);
            d_in[i] = 32'hA000_0000 + DW'(i);
        end
        for (int r = 0; r < 12; r++) begin
            run_cycle(tab[r].v, tab[r].we);
            chk($sformatf("tab%0d_ready", r), req_ready, tab[r].rdy);
        end

        a_in[0] = 11'h7FF;
        d_in[0] = 32'hDEAD_BEEF;
        a_in[2] = 11'h7FF;
        run_cycle(4'b0101, 4'b0001);
        run_cycle(4'b0100, 4'b0000);
        chk("bypass", {rsp_valid[2], rsp_rdata[95:64]}, {1'b1, 32'hDEAD_BEEF});
        run_cycle(4'b0000, 4'b0000);
        chk("after_wr", {rsp_valid[2], rsp_rdata[95:64]}, {1'b1, 32'hDEAD_BEEF});

        for (int n = 0; n < 100; n++) begin
            w = $urandom_range(0, NREQ - 1);
            v = 4'b1111;
            if ($urandom_range(0, 1) == 1) begin
                dr = $urandom_range(0, NREQ - 1);
                if (dr != w) v[dr] = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                a_in[i] = ($urandom_range(0, 1) == 1) ?
                          AW'($urandom_range(0, 7)) : AW'($urandom);
                d_in[i] = $urandom;
            end
            run_cycle(v, 4'(1 << w));
        end
        run_cycle(4'b0000, 4'b0000);

        a_in[0] = 11'd20;
        a_in[1] = 11'd21;
        run_cycle(4'b0011, 4'b0000);
        reset_for(1);
        init_phase();
        model_reset();
        run_cycle(4'b1111, 4'b0000);
        chk("ptr_reset", req_ready, 4'b0011);
        run_cycle(4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
